// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types and helpers for the data-memory controller.
//   state_e   : controller FSM states
//   req_id_e  : requester identity (also the round-robin pointer encoding)
//   BE_FULL   : byte-enable value meaning a whole-word access
//   be_to_mask: expands 4 byte enables into a 32-bit lane mask
package dmem_ctrl_pkg;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_e;

  typedef enum logic {
    REQ_CORE,
    REQ_AUX
  } req_id_e;

  localparam logic [3:0] BE_FULL = 4'hF;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/dmem_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_req[1:0] : request vector, bit 0 = core, bit 1 = aux
//   i_advance  : a grant was taken this cycle; move the pointer
//   o_gnt[1:0] : one-hot combinational grant
// The pointer names the requester favoured on a tie and moves to the
// loser of every grant, so back-to-back contention alternates.
module rr_arb2
  import dmem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic [1:0] o_gnt
);

  req_id_e r_ptr;

  always_comb begin
    o_gnt = '0;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (r_ptr == REQ_CORE) ? 2'b01 : 2'b10;
      default: o_gnt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= REQ_CORE;
    end else if (i_advance) begin
      r_ptr <= o_gnt[0] ? REQ_AUX : REQ_CORE;
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: shares a single-port, word-addressed data memory between the
// pipeline MEM stage (c_*) and the program/debug loader (a_*).
//   c_req/we/be/addr/wdata, a_*   : request ports (req held until gnt)
//   c_gnt, a_gnt                  : combinational accept, IDLE only
//   c_rvalid/rdata/err, a_*       : registered response, 1 cycle after gnt
//   mem_we/addr/wd, mem_rd        : memory port (async read, whole-word write)
// Sub-word stores become a read-modify-write: the grant cycle reads and
// merges, RMW_WR writes the merged word back. Out-of-range accesses are
// granted, never written, and answered with err.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WORDS = 64,
  parameter int unsigned AW         = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [3:0]    c_be,
  input  logic [AW-1:0] c_addr,
  input  logic [31:0]   c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [31:0]   c_rdata,
  output logic          c_err,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [3:0]    a_be,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [31:0]   a_rdata,
  output logic          a_err,
  output logic          mem_we,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wd,
  input  logic [31:0]   mem_rd
);

  state_e        r_state;
  logic [31:0]   r_rmw_addr;
  logic [31:0]   r_rmw_data;
  logic          r_c_rvalid, r_c_err, r_a_rvalid, r_a_err;
  logic [31:0]   r_c_rdata, r_a_rdata;

  logic [1:0]    w_arb_req, w_gnt;
  logic          w_any_gnt;
  logic          w_we;
  logic [3:0]    w_be;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_wdata, w_mask, w_merged, w_resp_data;
  logic          w_in_range, w_full, w_partial, w_resp_valid;

  // Requests are hidden from the arbiter while in RMW_WR or in reset, so no
  // grant escapes and the pointer holds.
  assign w_arb_req = (rst_n && r_state == IDLE) ? {a_req, c_req} : 2'b00;
  assign w_any_gnt = |w_gnt;

  rr_arb2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (w_arb_req),
    .i_advance (w_any_gnt),
    .o_gnt     (w_gnt)
  );

  assign c_gnt = w_gnt[0];
  assign a_gnt = w_gnt[1];

  assign w_we    = w_gnt[1] ? a_we    : c_we;
  assign w_be    = w_gnt[1] ? a_be    : c_be;
  assign w_addr  = w_gnt[1] ? a_addr  : c_addr;
  assign w_wdata = w_gnt[1] ? a_wdata : c_wdata;

  assign w_in_range = (32'(w_addr[AW-1:2]) < ADDR_WORDS);
  assign w_full     = w_we && w_in_range && (w_be == BE_FULL);
  assign w_partial  = w_we && w_in_range && (w_be != BE_FULL) && (w_be != '0);
  assign w_mask     = be_to_mask(w_be);
  assign w_merged   = (mem_rd & ~w_mask) | (w_wdata & w_mask);

  // Reads and every out-of-range access answer; in-range writes are silent.
  assign w_resp_valid = w_any_gnt && (!w_we || !w_in_range);
  assign w_resp_data  = (!w_we && w_in_range) ? mem_rd : '0;

  always_comb begin
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    if (r_state == RMW_WR) begin
      mem_we   = 1'b1;
      mem_addr = r_rmw_addr;
      mem_wd   = r_rmw_data;
    end else if (w_any_gnt) begin
      mem_addr = 32'(w_addr);
      if (w_full) begin
        mem_we = 1'b1;
        mem_wd = w_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rmw_addr <= '0;
      r_rmw_data <= '0;
      r_c_rvalid <= 1'b0;
      r_c_err    <= 1'b0;
      r_c_rdata  <= '0;
      r_a_rvalid <= 1'b0;
      r_a_err    <= 1'b0;
      r_a_rdata  <= '0;
    end else begin
      r_c_rvalid <= 1'b0;
      r_c_err    <= 1'b0;
      r_a_rvalid <= 1'b0;
      r_a_err    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt[0]) begin
            r_c_rvalid <= w_resp_valid;
            r_c_err    <= w_resp_valid && !w_in_range;
            if (w_resp_valid) r_c_rdata <= w_resp_data;
          end
          if (w_gnt[1]) begin
            r_a_rvalid <= w_resp_valid;
            r_a_err    <= w_resp_valid && !w_in_range;
            if (w_resp_valid) r_a_rdata <= w_resp_data;
          end
          if (w_partial) begin
            r_state    <= RMW_WR;
            r_rmw_addr <= 32'(w_addr);
            r_rmw_data <= w_merged;
          end
        end
        RMW_WR:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign c_rvalid = r_c_rvalid;
  assign c_rdata  = r_c_rdata;
  assign c_err    = r_c_err;
  assign a_rvalid = r_a_rvalid;
  assign a_rdata  = r_a_rdata;
  assign a_err    = r_a_err;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl with a 64-word behavioural
// memory (async read, write on rising edge). Inputs change on the falling
// edge; combinational outputs are sampled 1 time unit later, registered
// responses one falling edge after the grant.
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        c_req, c_we, a_req, a_we;
  logic [3:0]  c_be, a_be;
  logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
  logic        c_gnt, c_rvalid, c_err, a_gnt, a_rvalid, a_err;
  logic [31:0] c_rdata, a_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic [31:0] mem [64];
  logic        pl_we = 1'b0;
  logic [5:0]  pl_idx = '0;
  logic [31:0] pl_data = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    else if (pl_we) mem[pl_idx] <= pl_data;
  end

  dmem_ctrl #(.ADDR_WORDS(64), .AW(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .c_req(c_req), .c_we(c_we), .c_be(c_be), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
    .a_req(a_req), .a_we(a_we), .a_be(a_be), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    @(negedge clk);
    pl_idx = idx; pl_data = data; pl_we = 1'b1;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    c_req = 0; c_we = 0; c_be = '0; c_addr = '0; c_wdata = '0;
    a_req = 0; a_we = 0; a_be = '0; a_addr = '0; a_wdata = '0;
    preload(6'd0, 32'h0);
    preload(6'd1, 32'h11223344);
    preload(6'd2, 32'hDEADBEEF);
    preload(6'd3, 32'h0);
    #1;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_c_rdata", c_rdata, 0);
    chk("rst_mem_we", mem_we, 0);
    @(negedge clk); rst_n = 1'b1;

    // 1: core read of word 2
    @(negedge clk); c_req = 1; c_we = 0; c_addr = 32'h8;
    #1;
    chk("t1_c_gnt", c_gnt, 1);
    chk("t1_mem_we", mem_we, 0);
    chk("t1_mem_addr", mem_addr, 32'h8);
    @(negedge clk); c_req = 0;
    #1;
    chk("t1_c_rvalid", c_rvalid, 1);
    chk("t1_c_rdata", c_rdata, 32'hDEADBEEF);
    chk("t1_c_err", c_err, 0);
    chk("t1_mem_we_after", mem_we, 0);
    @(negedge clk); #1;
    chk("t1_rvalid_pulse", c_rvalid, 0);

    // 2: core SB to word 1, aux read arrives during RMW_WR
    @(negedge clk); c_req = 1; c_we = 1; c_be = 4'b0010; c_addr = 32'h4; c_wdata = 32'h0000AB00;
    #1;
    chk("t2_c_gnt", c_gnt, 1);
    chk("t2_mem_we_grant", mem_we, 0);
    @(negedge clk); c_req = 0; c_we = 0; a_req = 1; a_we = 0; a_addr = 32'h8;
    #1;
    chk("t2_mem_we_rmw", mem_we, 1);
    chk("t2_mem_addr_rmw", mem_addr, 32'h4);
    chk("t2_mem_wd_rmw", mem_wd, 32'h1122AB44);
    chk("t2_a_gnt_blocked", a_gnt, 0);
    chk("t2_c_rvalid_none", c_rvalid, 0);
    @(negedge clk); #1;
    chk("t2_a_gnt_after", a_gnt, 1);
    chk("t2_mem_we_after", mem_we, 0);
    chk("t2_word1", mem[1], 32'h1122AB44);
    @(negedge clk); a_req = 0;
    #1;
    chk("t2_a_rvalid", a_rvalid, 1);
    chk("t2_a_rdata", a_rdata, 32'hDEADBEEF);

    // 3: continuous contention from reset
    @(negedge clk); rst_n = 0;
    @(negedge clk); rst_n = 1;
    c_req = 1; c_we = 0; c_addr = 32'h8;
    a_req = 1; a_we = 0; a_addr = 32'h4;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t3_c_gnt_%0d", k), c_gnt, (k % 2 == 0));
      chk($sformatf("t3_a_gnt_%0d", k), a_gnt, (k % 2 == 1));
      chk($sformatf("t3_c_rvalid_%0d", k), c_rvalid, (k % 2 == 1));
      chk($sformatf("t3_a_rvalid_%0d", k), a_rvalid, (k >= 2 && k % 2 == 0));
      if (k % 2 == 1) chk($sformatf("t3_c_rdata_%0d", k), c_rdata, 32'hDEADBEEF);
      if (k == 2) chk("t3_a_rdata_2", a_rdata, 32'h1122AB44);
      @(negedge clk);
    end
    c_req = 0; a_req = 0;
    #1;
    chk("t3_a_rvalid_last", a_rvalid, 1);
    chk("t3_c_rvalid_last", c_rvalid, 0);

    // 4: aux full-word write out of range
    @(negedge clk); a_req = 1; a_we = 1; a_be = 4'hF; a_addr = 32'h100; a_wdata = 32'h55555555;
    #1;
    chk("t4_a_gnt", a_gnt, 1);
    chk("t4_mem_we", mem_we, 0);
    @(negedge clk); a_req = 0; a_we = 0;
    #1;
    chk("t4_a_rvalid", a_rvalid, 1);
    chk("t4_a_err", a_err, 1);
    chk("t4_a_rdata", a_rdata, 0);
    chk("t4_word0", mem[0], 0);

    // be=0 write: granted, silent, no memory write
    @(negedge clk); c_req = 1; c_we = 1; c_be = 4'h0; c_addr = 32'h8; c_wdata = 32'h12345678;
    #1;
    chk("tz_c_gnt", c_gnt, 1);
    chk("tz_mem_we", mem_we, 0);
    @(negedge clk); c_req = 0; c_we = 0;
    #1;
    chk("tz_c_rvalid", c_rvalid, 0);
    chk("tz_word2", mem[2], 32'hDEADBEEF);

    // 5: reset during RMW_WR (pointer favours aux before the reset)
    @(negedge clk); c_req = 1; c_we = 1; c_be = 4'b0001; c_addr = 32'hC; c_wdata = 32'h000000AA;
    #1;
    chk("t5_c_gnt", c_gnt, 1);
    @(negedge clk); c_req = 0; c_we = 0;
    #1;
    chk("t5_mem_we_rmw", mem_we, 1);
    chk("t5_mem_wd_rmw", mem_wd, 32'h000000AA);
    #1; rst_n = 0;
    #1;
    chk("t5_mem_we_reset", mem_we, 0);
    @(negedge clk); rst_n = 1;
    #1;
    chk("t5_word3", mem[3], 0);
    chk("t5_mem_we_idle", mem_we, 0);
    @(negedge clk); c_req = 1; c_addr = 32'h8; a_req = 1; a_addr = 32'h4;
    #1;
    chk("t5_c_gnt_ptr", c_gnt, 1);
    chk("t5_a_gnt_ptr", a_gnt, 0);
    @(negedge clk); c_req = 0; a_req = 0;

    // 6: full-word store then read-back
    @(negedge clk); c_req = 1; c_we = 1; c_be = 4'hF; c_addr = 32'h0; c_wdata = 32'hCAFEF00D;
    #1;
    chk("t6_c_gnt_wr", c_gnt, 1);
    chk("t6_mem_we", mem_we, 1);
    chk("t6_mem_wd", mem_wd, 32'hCAFEF00D);
    @(negedge clk); c_we = 0;
    #1;
    chk("t6_c_gnt_rd", c_gnt, 1);
    chk("t6_c_rvalid_wr", c_rvalid, 0);
    chk("t6_mem_we_rd", mem_we, 0);
    @(negedge clk); c_req = 0;
    #1;
    chk("t6_c_rvalid", c_rvalid, 1);
    chk("t6_c_rdata", c_rdata, 32'hCAFEF00D);
    chk("t6_c_err", c_err, 0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Sequences and shares the single-port, word-addressed data memory between two requesters:
  - the pipeline MEM stage (core port, c_*);
  - the program/debug loader (aux port, a_*).
- Round-robin arbitration.
- Sub-word stores (SB/SH) become a two-cycle read-modify-write, because the memory only accepts whole-word writes.
- Reads return one cycle after grant.
- Sits between the MEM stage / loader and the data memory instance.

Parameters:
- ADDR_WORDS, 64: memory depth in 32-bit words. Legal word index is addr[31:2] < ADDR_WORDS.
- AW, 32: byte-address width of the request ports.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- c_req  in  1  core request valid; held until c_gnt.
- c_we  in  1  core write (1) / read (0).
- c_be  in  4  core byte enables, lane i = bits [8i+7:8i].
- c_addr  in  AW  core byte address; bits [1:0] ignored.
- c_wdata  in  32  core write data, already lane-aligned.
- c_gnt  out  1  core request accepted this cycle.
- c_rvalid  out  1  core read data / error valid.
- c_rdata  out  32  core read data.
- c_err  out  1  out-of-range access, valid with c_rvalid.
- a_req, a_we, a_be, a_addr, a_wdata  in  same as c_*  aux port.
- a_gnt, a_rvalid, a_rdata, a_err  out  same as c_*  aux port.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory byte address.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory asynchronous read data.

Behaviour:
- Reset (async, rst_n=0):
  - FSM=IDLE; rr pointer = core.
  - All gnt, rvalid, err = 0; rdata = 0.
  - mem_we = 0 immediately.
  - Any in-flight RMW is abandoned with no write.
- FSM states: IDLE, RMW_WR.
- IDLE, arbitration:
  - Only one requester asserting req: it wins.
  - Both asserting: the winner is the one the rr pointer favours.
  - Pointer moves to the loser after every grant.
  - gnt is combinational in IDLE, one winner per cycle.
- Granted read:
  - mem_addr = req addr, mem_we = 0.
  - mem_rd registered into x_rdata; x_rvalid = 1 on the next cycle only (latency 1).
- Granted write with be=4'hF: mem_we = 1, mem_wd = wdata, write lands at that edge; no rvalid.
- Granted write with be = 4'h0: no memory write, no rvalid; counts as a grant.
- Granted partial write (be not 4'hF and not 0):
  - Latch addr.
  - Latch merged = (mem_rd & ~mask(be)) | (wdata & mask(be)).
  - Go to RMW_WR; mem_we = 0 in the grant cycle.
- RMW_WR:
  - mem_we = 1, mem_addr / mem_wd from the latched values.
  - No grants issued in this state.
  - Return to IDLE next cycle.
  - Total occupancy: 2 cycles.
- Out of range (addr[31:2] >= ADDR_WORDS):
  - Granted normally, mem_we forced 0.
  - Next cycle: x_rvalid = 1, x_err = 1, x_rdata = 0, for both reads and writes.
- rvalid/err are single-cycle pulses and never stall; requesters must accept them.
- Memory-side outputs are combinational from FSM state and the granted request. Idle values: mem_we = 0, mem_addr = 0, mem_wd = 0.
- A requester may re-request in the cycle after its gnt. The rr pointer still favours the other requester if both are active.

Decomposition:
- Package dmem_ctrl_pkg:
  - state_e {IDLE, RMW_WR};
  - req_id_e {REQ_CORE, REQ_AUX};
  - BE_FULL = 4'hF;
  - function be_to_mask(be) returning the 32-bit mask.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], advance.
  - Outputs: gnt[1:0] one-hot.
  - Internal pointer with its own async reset.

Test Plan:
1. Reset, then core reads addr 0x8 with mem word[2]=0xDEADBEEF → c_gnt in cycle 0, c_rvalid=1 with c_rdata=0xDEADBEEF in cycle 1, mem_we never asserted.
2. Core SB: addr 0x4, be=4'b0010, wdata=0x0000AB00, word[1]=0x11223344 → mem_we=0 in the grant cycle, mem_we=1 with mem_wd=0x1122AB44 in the next cycle. A concurrent a_req is not granted until the cycle after.
3. Core and aux both request continuously (reads) from reset → gnt alternates core, aux, core, aux. Each rvalid arrives one cycle after its own gnt.
4. Aux writes addr 0x100 (word 64, ADDR_WORDS=64) with be=4'hF → a_gnt, mem_we stays 0, next cycle a_rvalid=1, a_err=1, a_rdata=0.
5. rst_n pulled low during RMW_WR → mem_we drops immediately; after release FSM is IDLE, target word unchanged, rr pointer = core.
6. Full-word store 0xCAFEF00D to addr 0x0, then a read of 0x0 in the next cycle → c_rdata=0xCAFEF00D one cycle after the read grant.
